a2d_conv_sched: RTL and testbench

- Sequences the shared A2D SPI master through round-robin conversions of the four analog channels: BATT, CURR, BRAKE, TORQUE.
- Each conversion is two SPI transactions: a channel-select command, then a read-back. Conversions are separated by a programmable gap.
- Holds the latest 12-bit result per channel for the sensorless/PID datapath, and flags SPI transactions that never complete.

---
 rtl/a2d_conv_sched.sv | 168 ++++++++++++++++
 tb/tb_a2d_conv_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_conv_sched.sv
// a2d_conv_sched: round-robin A2D conversion sequencer for a shared SPI master.
// Each conversion issues a channel-select command and then a read-back.
// Conversions are spaced by a programmable gap. The latest 12-bit result per
// channel is held, and SPI transactions that never complete are flagged.
module a2d_conv_sched #(
  parameter int         GAP_CYCLES = 2048,
  parameter int         TIMEOUT    = 255,
  parameter logic [2:0] CH_BATT    = 3'd0,
  parameter logic [2:0] CH_CURR    = 3'd1,
  parameter logic [2:0] CH_BRAKE   = 3'd3,
  parameter logic [2:0] CH_TORQUE  = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr_err,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic [3:0]  chnl_vld,
  output logic        cnv_cmplt,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GAP,
    S_CMD,
    S_WAIT1,
    S_HOLD,
    S_READ,
    S_WAIT2,
    S_ABORT,
    S_NEXT
  } state_t;

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [9:0]  TMO_LAST = 10'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_ptr;
  logic [15:0] r_gap_cnt;
  logic [9:0]  r_tmo_cnt;

  logic        r_wrt;
  logic [15:0] r_cmd;
  logic [3:0]  r_chnl_vld;
  logic        r_cnv_cmplt;
  logic        r_timeout_err;
  logic [11:0] r_res [4];

  logic [2:0]  w_ch;
  logic        w_tmo_hit;
  logic        w_rd_ok;
  logic        w_chan_end;
  logic        w_unused_rd_hi;

  // Only the low 12 bits of the read-back carry the conversion result.
  assign w_unused_rd_hi = ^rd_data[15:12];

  // Map the round-robin pointer to the A2D channel number.
  always_comb begin
    w_ch = CH_BATT;
    case (r_ptr)
      2'd0: w_ch = CH_BATT;
      2'd1: w_ch = CH_CURR;
      2'd2: w_ch = CH_BRAKE;
      2'd3: w_ch = CH_TORQUE;
      default: w_ch = CH_BATT;
    endcase
  end

  // The counter reaches TIMEOUT-1 on this clock: the wait is over.
  assign w_tmo_hit  = ((r_tmo_cnt + 10'd1) == TMO_LAST);
  // Read-back completed: the result is captured on this edge.
  assign w_rd_ok    = (r_state == S_WAIT2) && done;
  // Current channel is finished, either with data or by abort.
  assign w_chan_end = w_rd_ok || (r_state == S_ABORT);

  // Next-state logic; done only matters while waiting on a transaction.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_next = S_GAP;
      S_GAP:   if (r_gap_cnt == GAP_LAST) w_state_next = S_CMD;
      S_CMD:   w_state_next = S_WAIT1;
      S_WAIT1: begin
        if (done)           w_state_next = S_HOLD;
        else if (w_tmo_hit) w_state_next = S_ABORT;
      end
      S_HOLD:  w_state_next = S_READ;
      S_READ:  w_state_next = S_WAIT2;
      S_WAIT2: begin
        if (done)           w_state_next = S_NEXT;
        else if (w_tmo_hit) w_state_next = S_ABORT;
      end
      S_ABORT: w_state_next = S_NEXT;
      S_NEXT:  w_state_next = en ? S_GAP : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register, gap/timeout counters and channel pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_gap_cnt <= 16'd0;
      r_tmo_cnt <= 10'd0;
    end else begin
      r_state <= w_state_next;
      // Counters are held at zero outside their states, so entry always starts at 0.
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 16'd1;
      else                  r_gap_cnt <= 16'd0;
      if ((r_state == S_WAIT1) || (r_state == S_WAIT2)) r_tmo_cnt <= r_tmo_cnt + 10'd1;
      else                                              r_tmo_cnt <= 10'd0;
      if (w_chan_end) r_ptr <= r_ptr + 2'd1;
    end
  end

  // Registered SPI strobe/command plus per-channel strobe, round-end pulse and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrt         <= 1'b0;
      r_cmd         <= 16'h0000;
      r_chnl_vld    <= 4'd0;
      r_cnv_cmplt   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Decoding from the next state makes wrt high exactly during CMD and READ.
      r_wrt <= (w_state_next == S_CMD) || (w_state_next == S_READ);
      if (w_state_next == S_CMD) r_cmd <= {2'b00, w_ch, 11'h000};
      r_chnl_vld  <= w_rd_ok ? (4'b0001 << r_ptr) : 4'd0;
      r_cnv_cmplt <= w_chan_end && (r_ptr == 2'd3);
      // A new abort takes priority over a coincident clear.
      if (r_state == S_ABORT) r_timeout_err <= 1'b1;
      else if (clr_err)       r_timeout_err <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_res
      // Capture the read-back into this channel's result register.
      always_ff @(posedge clk) begin
        if (rst)                                r_res[gi] <= 12'd0;
        else if (w_rd_ok && (r_ptr == 2'(gi)))  r_res[gi] <= rd_data[11:0];
      end
    end
  endgenerate

  assign wrt         = r_wrt;
  assign cmd         = r_cmd;
  assign batt        = r_res[0];
  assign curr        = r_res[1];
  assign brake       = r_res[2];
  assign torque      = r_res[3];
  assign chnl_vld    = r_chnl_vld;
  assign cnv_cmplt   = r_cnv_cmplt;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Directed bench for a2d_conv_sched: rounds, wrap-around, timeouts, en drop, reset.
module tb_a2d_conv_sched;
  localparam int GAP = 4;
  localparam int TMO = 8;
  localparam int DLY = 3;

  logic        clk = 1'b0;
  logic        rst, en, clr_err, done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] batt, curr, brake, torque;
  logic [3:0]  chnl_vld;
  logic        cnv_cmplt, timeout_err;

  a2d_conv_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .batt(batt), .curr(curr), .brake(brake), .torque(torque),
    .chnl_vld(chnl_vld), .cnv_cmplt(cnv_cmplt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int tick_num = 0;
  int wrt_cnt = 0;
  int resp_cnt = -1;
  int cmplt_cnt = 0;
  int t_wh = -1;
  int lat;
  int w0;
  int k;
  bit echo = 0;
  bit withhold = 0;
  bit found;
  logic        prev_wrt = 1'b0;
  logic [15:0] resp_data [8];
  logic [15:0] cmd_q [$];
  logic [3:0]  vld_q [$];
  logic [3:0]  cmplt_vld = 4'd0;
  logic [15:0] last_cmd = 16'h0;
  logic [15:0] exp_cmd [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, run protocol checks, then drive the SPI responder.
  task automatic tick();
    @(negedge clk);
    tick_num++;
    chk("wrt_back_to_back", {31'd0, wrt && prev_wrt}, 0);
    chk("vld_onehot0", {31'd0, $onehot0(chnl_vld)}, 1);
    prev_wrt = wrt;
    if (chnl_vld != 4'd0) vld_q.push_back(chnl_vld);
    if (cnv_cmplt) begin
      cmplt_cnt++;
      cmplt_vld = chnl_vld;
    end
    done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        done = 1'b1;
        rd_data = resp_data[last_cmd[13:11]];
        resp_cnt = -1;
      end
    end
    if (wrt === 1'b1) begin
      cmd_q.push_back(cmd);
      last_cmd = cmd;
      if (withhold && cmd == 16'h0800 && (wrt_cnt % 2) == 1) t_wh = tick_num;
      else resp_cnt = DLY;
      if (echo) begin
        done = 1'b1;
        rd_data = 16'hDEAD;
      end
      wrt_cnt++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wrt"}, {31'd0, wrt}, 0);
    chk({tag, "_cmd"}, {16'd0, cmd}, 0);
    chk({tag, "_batt"}, {20'd0, batt}, 0);
    chk({tag, "_curr"}, {20'd0, curr}, 0);
    chk({tag, "_brake"}, {20'd0, brake}, 0);
    chk({tag, "_torque"}, {20'd0, torque}, 0);
    chk({tag, "_vld"}, {28'd0, chnl_vld}, 0);
    chk({tag, "_cmplt"}, {31'd0, cnv_cmplt}, 0);
    chk({tag, "_tmo"}, {31'd0, timeout_err}, 0);
  endtask

  task automatic wait_cmplt(input int target);
    int n = 0;
    while (cmplt_cnt < target && n < 1000) begin tick(); n++; end
    chk("wait_cmplt", {31'd0, cmplt_cnt >= target}, 1);
  endtask

  task automatic wait_wrt();
    int n = 0;
    int base = wrt_cnt;
    while (wrt_cnt == base && n < 300) begin tick(); n++; end
    chk("wait_wrt", {31'd0, wrt_cnt > base}, 1);
  endtask

  task automatic wait_withheld();
    int n = 0;
    while (t_wh < 0 && n < 400) begin tick(); n++; end
    chk("wait_withheld_read", {31'd0, t_wh >= 0}, 1);
    n = 0;
    while (tick_num < t_wh + TMO && n < 100) begin tick(); n++; end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; done = 1'b0; rd_data = 16'h0;
    for (int i = 0; i < 8; i++) resp_data[i] = 16'h0;
    resp_data[0] = 16'h0ABC; resp_data[1] = 16'h0123;
    resp_data[3] = 16'h0FF0; resp_data[4] = 16'h0500;
    exp_cmd[0] = 16'h0000; exp_cmd[1] = 16'h0000; exp_cmd[2] = 16'h0800; exp_cmd[3] = 16'h0800;
    exp_cmd[4] = 16'h1800; exp_cmd[5] = 16'h1800; exp_cmd[6] = 16'h2000; exp_cmd[7] = 16'h2000;

    // Reset state
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_no_wrt", {31'd0, wrt}, 0);

    // Latency from en to first wrt, then one full round
    en = 1'b1; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (wrt) begin lat = i; break; end
    end
    chk("first_wrt_latency", lat, GAP + 1);
    wait_cmplt(1);
    chk("r1_cmd_count", cmd_q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("r1_cmd%0d", i), {16'd0, cmd_q[i]}, {16'd0, exp_cmd[i]});
    chk("r1_batt", {20'd0, batt}, 32'hABC);
    chk("r1_curr", {20'd0, curr}, 32'h123);
    chk("r1_brake", {20'd0, brake}, 32'hFF0);
    chk("r1_torque", {20'd0, torque}, 32'h500);
    chk("r1_vld_count", vld_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("r1_vld%0d", i), {28'd0, vld_q[i]}, 32'd1 << i);
    chk("r1_cmplt_with_torque", {28'd0, cmplt_vld}, 8);

    // Wrap-around: two more rounds, done echoed alongside every wrt
    cmd_q.delete(); vld_q.delete(); echo = 1;
    resp_data[0] = 16'hF111; resp_data[1] = 16'hF222; resp_data[3] = 16'hF333; resp_data[4] = 16'hF444;
    wait_cmplt(2);
    chk("r2_batt", {20'd0, batt}, 32'h111);
    chk("r2_curr", {20'd0, curr}, 32'h222);
    chk("r2_brake", {20'd0, brake}, 32'h333);
    chk("r2_torque", {20'd0, torque}, 32'h444);
    resp_data[0] = 16'h0FFF; resp_data[1] = 16'hF456; resp_data[3] = 16'h0001; resp_data[4] = 16'h0800;
    wait_cmplt(3);
    chk("r3_batt", {20'd0, batt}, 32'hFFF);
    chk("r3_curr", {20'd0, curr}, 32'h456);
    chk("r3_brake", {20'd0, brake}, 32'h001);
    chk("r3_torque", {20'd0, torque}, 32'h800);
    chk("r23_vld_count", vld_q.size(), 8);
    chk("r23_cmd_count", cmd_q.size(), 16);
    chk("r3_starts_batt", {16'd0, cmd_q[8]}, 0);
    chk("r3_cmplt_with_torque", {28'd0, cmplt_vld}, 8);

    // Timeout on the CURR read-back
    echo = 0; withhold = 1; t_wh = -1; vld_q.delete();
    resp_data[0] = 16'hF000; resp_data[1] = 16'h0999; resp_data[3] = 16'h0AAA; resp_data[4] = 16'h0BBB;
    wait_withheld();
    chk("tmo_not_yet", {31'd0, timeout_err}, 0);
    tick();
    chk("tmo_set", {31'd0, timeout_err}, 1);
    chk("tmo_curr_kept", {20'd0, curr}, 32'h456);
    chk("r4_batt_zero", {20'd0, batt}, 0);
    wait_wrt();
    chk("cmd_after_abort", {16'd0, last_cmd}, 32'h1800);
    found = 0;
    foreach (vld_q[i]) if (vld_q[i][1]) found = 1;
    chk("no_curr_vld", {31'd0, found}, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo_clr", {31'd0, timeout_err}, 0);

    // clr_err coincident with a fresh abort: set wins
    t_wh = -1;
    wait_withheld();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo_set_wins", {31'd0, timeout_err}, 1);
    withhold = 0;

    // en dropped during BRAKE WAIT1
    resp_data[3] = 16'h0CDE; vld_q.delete();
    wait_wrt();
    chk("brake_cmd", {16'd0, last_cmd}, 32'h1800);
    tick();
    en = 1'b0;
    k = 0;
    while (vld_q.size() == 0 && k < 100) begin tick(); k++; end
    chk("brake_vld", {28'd0, vld_q[0]}, 4);
    chk("brake_val", {20'd0, brake}, 32'hCDE);
    w0 = wrt_cnt;
    repeat (40) tick();
    chk("idle_no_wrt_after_drop", wrt_cnt - w0, 0);
    en = 1'b1; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (wrt) begin lat = i; break; end
    end
    chk("resume_latency", lat, GAP + 1);
    chk("resume_cmd", {16'd0, cmd}, 32'h2000);

    // Reset during WAIT2 with a late done still pending
    wait_wrt();
    tick();
    en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("rst_mid");
    wrt_cnt = 0; vld_q.delete();
    repeat (10) tick();
    chk("late_done_batt", {20'd0, batt}, 0);
    chk("late_done_torque", {20'd0, torque}, 0);
    chk("late_done_vld", vld_q.size(), 0);
    chk("late_done_wrt", wrt_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
